cvbs_sync_gen: RTL and testbench
================================

// Module: cvbs_sync_gen
// PURPOSE
//  Synthesisable, mode-selectable composite-video sync/test-pattern source used as stimulus for
//  syncdetect and on-board loopback. Generates one 24 MHz CVBS sample stream in PAL-normal, BK or
//  Vector sync styles, or a no-sync idle level. Optional DC-floor drift models the vector AC-coupled
//  wander. Registered ground-truth hsync/vsync/position let a checker score the detector.
// PARAMETERS
//  W=6             cvbs sample width
//  LINE=1536       clocks per line (64 us)
//  LINES=312       lines per frame
//  FPORCH=40       front porch clocks
//  HS=113          normal/BK hsync clocks (4.7 us)
//  HS_VEC=257      vector hsync clocks (10.7 us)
//  BPORCH=137      back porch clocks
//  SSYNC=48        short/equalising pulse clocks
//  LSYNC=720       long (broad) pulse clocks
//  EQP=528         BK equalising period clocks
//  VSYNC_LONG=672  vector vsync pulse clocks per line
//  BLACK=12        black level above floor
//  VIDEO_BASE=15   active-video ramp base
//  VEC_VS_LINES=23  vector lines carrying long vsync pulses
//  VEC_BLANK_END=25 first vector active line
//  BK_VS_LINES=3   BK vsync lines
//  DRIFT_EN=1      enable floor drift (vector mode only)
//  DRIFT_W=16      drift accumulator width
//  DRIFT_UP=2      drift increment
//  DRIFT_DN=6      drift decrement
//  DRIFT_RAMP=9216 ramp-up clocks from frame start (6 lines)
// PORTS
//  clk         in   1    sample clock
//  reset       in   1    asynchronous, active-high reset
//  ce          in   1    clock enable; all state holds when low
//  mode        in   2    00 normal, 01 BK, 10 vector, 11 idle (constant BLACK, no sync)
//  cvbs        out  W    composite sample
//  ref_hsync   out  1    high while cvbs is in an hsync pulse of a non-vsync line
//  ref_vsync   out  1    high for every clock of a vsync-region line
//  line_start  out  1    one-cycle pulse, pixel==0
//  frame_start out  1    one-cycle pulse, pixel==0 && line==0
//  line_no     out  9    current line (registered, aligned with cvbs)
//  pixel_no    out  11   current pixel (registered, aligned with cvbs)
// BEHAVIOUR
//  Reset: pixel=0, line=0, mode_q=00, drift acc=0, glob=0, eqp=0; cvbs=0, all flags 0, line_no=0,
//   pixel_no=0.
//  Counters, on ce only:
//   - pixel 0..LINE-1, wraps to 0 and advances line; line wraps LINES-1 -> 0.
//   - glob counts clocks since frame start (sat.); eqp counts 0..EQP-1, cleared at frame start.
//  mode_q loads from mode on each ce cycle with pixel==0 && line==0; that cycle already uses new mode.
//   A mode change mid-frame takes effect only at the next frame start.
//  Outputs: all registered, 1-cycle latency from (pixel,line) state; level L maps to
//   cvbs = min(floor+L, 2^W-1); sync level = floor+0.
//  Active line, normal/BK: pixel<FPORCH black; <FPORCH+HS sync; <+BPORCH black;
//   else VIDEO_BASE+pixel[3:0] (saturated, no floor).
//  Vector active line: same with HS_VEC, video unaffected by floor.
//  Normal vsync (lines 0-5): half-lines start at pixel 0 and LINE/2.
//   - Lines 0,1: both halves LSYNC sync then black.
//   - Line 2: first half LSYNC, second half SSYNC.
//   - Lines 3-5: both halves SSYNC.
//  BK vsync (lines 0..BK_VS_LINES-1): eqp<SSYNC black, else sync (inverted-equalising pattern).
//  Vector:
//   - Lines 0..VEC_VS_LINES-1: pixel<VSYNC_LONG sync else black.
//   - Lines ..VEC_BLANK_END-1: active timing but black instead of video.
//  Idle: cvbs=BLACK constantly; ref_hsync=ref_vsync=0; counters still run.
//  Drift (DRIFT_EN && mode_q==10):
//   - In vsync lines with glob<DRIFT_RAMP: acc+=DRIFT_UP, sat. at 2^DRIFT_W-1.
//   - Elsewhere: acc-=DRIFT_DN, clamped at 0 (acc<DRIFT_DN -> 0).
//   - floor=acc[DRIFT_W-1 -: 4]. Other modes force acc to 0.
//  ref_vsync: vsync-region lines of the active mode. ref_hsync: only during the sync portion of
//   active/blank lines.
//  Reset mid-frame: immediate return to reset values; first ce after release is line 0 pixel 0.
// TESTING
//  1. Normal, ce=1, reset release: line 0 cvbs=0 for pixels 0..719, =12 for 720..767, =0 at 768
//     -> frame_start one cycle after first ce.
//  2. Normal line 6: cvbs=12 at px 0..39, 0 at 40..152, 12 at 153..289, 15+px[3:0] from 290;
//     ref_hsync high exactly 113 clocks.
//  3. BK line 0: cvbs=12 for eqp 0..47, 0 for 48..527, repeating; ref_vsync=1 lines 0-2 only.
//  4. Vector, DRIFT_EN: floor rises to 4'hF-sat bounds by clock 9216, cvbs on line 0 px 700 =
//     floor+12; acc returns to 0 within 9216*2/6 clocks after ramp; never underflows.
//  5. Switch mode 00->10 at line 100: output stays normal until next frame_start, then vector timing.
//  6. ce toggled 1/0 every cycle: outputs advance every second clock, identical sample sequence;
//     reset asserted at line 50 -> cvbs=0, line_no=0 same cycle (async).

Source files
------------

// File: rtl/cvbs_sync_gen.sv
// cvbs_sync_gen: composite-video sync and test-pattern source.
// Produces a CVBS sample stream in PAL-normal, BK or vector sync style, or a
// constant black idle level. In vector mode an optional drifting DC floor
// models AC-coupled wander. Registered hsync/vsync/position outputs give a
// checker the ground truth for scoring a sync detector.
// Ports:
//   clk, reset      sample clock, asynchronous active-high reset
//   ce              clock enable; every register holds while low
//   mode            00 normal, 01 BK, 10 vector, 11 idle
//   cvbs            composite sample, W bits
//   ref_hsync       sync portion of an active/blank line
//   ref_vsync       whole vsync-region line
//   line_start      pulse at pixel 0
//   frame_start     pulse at pixel 0 of line 0
//   line_no         line index aligned with cvbs
//   pixel_no        pixel index aligned with cvbs
module cvbs_sync_gen #(
  parameter int unsigned W             = 6,
  parameter int unsigned LINE          = 1536,
  parameter int unsigned LINES         = 312,
  parameter int unsigned FPORCH        = 40,
  parameter int unsigned HS            = 113,
  parameter int unsigned HS_VEC        = 257,
  parameter int unsigned BPORCH        = 137,
  parameter int unsigned SSYNC         = 48,
  parameter int unsigned LSYNC         = 720,
  parameter int unsigned EQP           = 528,
  parameter int unsigned VSYNC_LONG    = 672,
  parameter int unsigned BLACK         = 12,
  parameter int unsigned VIDEO_BASE    = 15,
  parameter int unsigned VEC_VS_LINES  = 23,
  parameter int unsigned VEC_BLANK_END = 25,
  parameter int unsigned BK_VS_LINES   = 3,
  parameter int unsigned DRIFT_EN      = 1,
  parameter int unsigned DRIFT_W       = 16,
  parameter int unsigned DRIFT_UP      = 2,
  parameter int unsigned DRIFT_DN      = 6,
  parameter int unsigned DRIFT_RAMP    = 9216
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce,
  input  logic [1:0]   mode,
  output logic [W-1:0] cvbs,
  output logic         ref_hsync,
  output logic         ref_vsync,
  output logic         line_start,
  output logic         frame_start,
  output logic [8:0]   line_no,
  output logic [10:0]  pixel_no
);

  localparam int unsigned PX_W          = 11;
  localparam int unsigned LN_W          = 9;
  localparam int unsigned LVL_W         = W + 5;
  localparam int unsigned ACC_W1        = DRIFT_W + 1;
  localparam int unsigned GLOB_W        = $clog2(DRIFT_RAMP + 1);
  localparam int unsigned EQP_W         = $clog2(EQP);
  localparam int unsigned MAX_LVL       = (2 ** W) - 1;
  localparam int unsigned HALF          = LINE / 2;
  localparam int unsigned NORM_VS_LINES = 6;

  localparam logic [1:0] MODE_NORMAL = 2'b00;
  localparam logic [1:0] MODE_BK     = 2'b01;
  localparam logic [1:0] MODE_VEC    = 2'b10;
  localparam logic [1:0] MODE_IDLE   = 2'b11;

  localparam logic [GLOB_W-1:0] GLOB_MAX = '1;

  logic [PX_W-1:0]    pixel_q, pixel_d;
  logic [LN_W-1:0]    line_q, line_d;
  logic [1:0]         mode_q, mode_d;
  logic [DRIFT_W-1:0] acc_q, acc_d;
  logic [GLOB_W-1:0]  glob_q, glob_d;
  logic [EQP_W-1:0]   eqp_q, eqp_d;
  logic [W-1:0]       cvbs_q, cvbs_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               lstart_q, lstart_d;
  logic               fstart_q, fstart_d;
  logic [LN_W-1:0]    line_no_q;
  logic [PX_W-1:0]    pixel_no_q;

  logic               frame_wrap;
  logic               frame_pos;
  logic [PX_W-1:0]    half_px;
  logic [PX_W-1:0]    hs_len, hs_end, bp_end;
  logic               vs_line, sync_on, video_on, hs_on, active, video_en;
  logic               drift_on;
  logic [3:0]         floor_lvl;
  logic [LVL_W-1:0]   black_sum, sync_sum, video_sum;
  logic [ACC_W1-1:0]  acc_inc;

  // Clamp a level to the largest representable sample.
  function automatic logic [W-1:0] sat_lvl(input logic [LVL_W-1:0] v);
    return (v > LVL_W'(MAX_LVL)) ? W'(MAX_LVL) : v[W-1:0];
  endfunction

  // Pixel/line raster plus frame-relative glob and equalising-period counters.
  always_comb begin : counter_next
    pixel_d    = pixel_q + PX_W'(1);
    line_d     = line_q;
    glob_d     = glob_q;
    eqp_d      = eqp_q + EQP_W'(1);
    frame_wrap = 1'b0;
    if (pixel_q == PX_W'(LINE - 1)) begin
      pixel_d = '0;
      if (line_q == LN_W'(LINES - 1)) begin
        line_d     = '0;
        frame_wrap = 1'b1;
      end else begin
        line_d = line_q + LN_W'(1);
      end
    end
    if (glob_q != GLOB_MAX) glob_d = glob_q + GLOB_W'(1);
    if (eqp_q == EQP_W'(EQP - 1)) eqp_d = '0;
    if (frame_wrap) begin
      glob_d = '0;
      eqp_d  = '0;
    end
  end

  // Sample level, reference flags and drift for the current raster position.
  always_comb begin : sample_next
    frame_pos = (pixel_q == '0) && (line_q == '0);
    // The frame-start cycle already runs in the newly loaded mode.
    mode_d    = frame_pos ? mode : mode_q;
    half_px   = (pixel_q >= PX_W'(HALF)) ? pixel_q - PX_W'(HALF) : pixel_q;
    vs_line   = 1'b0;
    sync_on   = 1'b0;
    video_on  = 1'b0;
    hs_on     = 1'b0;
    active    = 1'b0;
    video_en  = 1'b1;
    hs_len    = PX_W'(HS);

    case (mode_d)
      MODE_NORMAL: begin
        if (line_q < LN_W'(NORM_VS_LINES)) begin
          vs_line = 1'b1;
          // Broad pulses on lines 0-1 and the first half of line 2.
          if ((line_q < LN_W'(2)) || ((line_q == LN_W'(2)) && (pixel_q < PX_W'(HALF))))
            sync_on = half_px < PX_W'(LSYNC);
          else
            sync_on = half_px < PX_W'(SSYNC);
        end else begin
          active = 1'b1;
        end
      end
      MODE_BK: begin
        if (line_q < LN_W'(BK_VS_LINES)) begin
          vs_line = 1'b1;
          // Inverted equalising: short black gap, long sync, free-running period.
          sync_on = eqp_q >= EQP_W'(SSYNC);
        end else begin
          active = 1'b1;
        end
      end
      MODE_VEC: begin
        if (line_q < LN_W'(VEC_VS_LINES)) begin
          vs_line = 1'b1;
          sync_on = pixel_q < PX_W'(VSYNC_LONG);
        end else begin
          active   = 1'b1;
          hs_len   = PX_W'(HS_VEC);
          video_en = line_q >= LN_W'(VEC_BLANK_END);
        end
      end
      default: ;
    endcase

    hs_end = PX_W'(FPORCH) + hs_len;
    bp_end = hs_end + PX_W'(BPORCH);
    if (active && (pixel_q >= PX_W'(FPORCH))) begin
      if (pixel_q < hs_end) begin
        sync_on = 1'b1;
        hs_on   = 1'b1;
      end else if (pixel_q >= bp_end) begin
        video_on = video_en;
      end
    end

    drift_on  = (DRIFT_EN != 0) && (mode_d == MODE_VEC);
    floor_lvl = drift_on ? acc_q[DRIFT_W-1 -: 4] : 4'd0;
    black_sum = LVL_W'(floor_lvl) + LVL_W'(BLACK);
    sync_sum  = LVL_W'(floor_lvl);
    video_sum = LVL_W'(VIDEO_BASE) + LVL_W'(pixel_q[3:0]);

    if (mode_d == MODE_IDLE) cvbs_d = W'(BLACK);
    else if (video_on)       cvbs_d = sat_lvl(video_sum);
    else if (sync_on)        cvbs_d = sat_lvl(sync_sum);
    else                     cvbs_d = sat_lvl(black_sum);

    // Floor ramps up during early vsync lines and bleeds off elsewhere.
    acc_inc = ACC_W1'(acc_q) + ACC_W1'(DRIFT_UP);
    acc_d   = '0;
    if (drift_on) begin
      if (vs_line && (glob_q < GLOB_W'(DRIFT_RAMP)))
        acc_d = acc_inc[DRIFT_W] ? '1 : acc_inc[DRIFT_W-1:0];
      else if (acc_q < DRIFT_W'(DRIFT_DN))
        acc_d = '0;
      else
        acc_d = acc_q - DRIFT_W'(DRIFT_DN);
    end

    hsync_d  = hs_on;
    vsync_d  = vs_line;
    lstart_d = pixel_q == '0;
    fstart_d = frame_pos;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_q    <= '0;
      line_q     <= '0;
      mode_q     <= MODE_NORMAL;
      acc_q      <= '0;
      glob_q     <= '0;
      eqp_q      <= '0;
      cvbs_q     <= '0;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
      lstart_q   <= 1'b0;
      fstart_q   <= 1'b0;
      line_no_q  <= '0;
      pixel_no_q <= '0;
    end else if (ce) begin
      pixel_q    <= pixel_d;
      line_q     <= line_d;
      mode_q     <= mode_d;
      acc_q      <= acc_d;
      glob_q     <= glob_d;
      eqp_q      <= eqp_d;
      cvbs_q     <= cvbs_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      lstart_q   <= lstart_d;
      fstart_q   <= fstart_d;
      line_no_q  <= line_q;
      pixel_no_q <= pixel_q;
    end
  end

  assign cvbs        = cvbs_q;
  assign ref_hsync   = hsync_q;
  assign ref_vsync   = vsync_q;
  assign line_start  = lstart_q;
  assign frame_start = fstart_q;
  assign line_no     = line_no_q;
  assign pixel_no    = pixel_no_q;

endmodule

// File: tb/tb_cvbs_sync_gen.sv
// tb_cvbs_sync_gen: randomized-enable bench for cvbs_sync_gen, checked against a
// frame-time reference model. Uses a 12-line frame so several frames fit.
module tb_cvbs_sync_gen;

  localparam int LINE   = 1536;
  localparam int LINES  = 12;
  localparam int FRAME  = LINE * LINES;
  localparam int FP     = 40;
  localparam int HS     = 113;
  localparam int HS_VEC = 257;
  localparam int BP     = 137;
  localparam int SSYNC  = 48;
  localparam int LSYNC  = 720;
  localparam int EQP    = 528;
  localparam int VSL    = 672;
  localparam int BKV    = 3;
  localparam int VVS    = 7;
  localparam int VBE    = 9;
  localparam int RAMP   = 9216;

  logic        clk;
  logic        reset;
  logic        ce;
  logic [1:0]  mode;
  logic [5:0]  cvbs;
  logic        ref_hsync, ref_vsync, line_start, frame_start;
  logic [8:0]  line_no;
  logic [10:0] pixel_no;
  logic [29:0] dut_bus;

  cvbs_sync_gen #(
    .LINES(LINES), .VEC_VS_LINES(VVS), .VEC_BLANK_END(VBE)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .mode(mode),
    .cvbs(cvbs), .ref_hsync(ref_hsync), .ref_vsync(ref_vsync),
    .line_start(line_start), .frame_start(frame_start),
    .line_no(line_no), .pixel_no(pixel_no)
  );

  assign dut_bus = {cvbs, ref_hsync, ref_vsync, line_start, frame_start, line_no, pixel_no};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          t      = 0;    // clocks since frame start, as seen by the model
  int          acc    = 0;
  logic [1:0]  mq     = 2'b00;
  logic [29:0] exp_q  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Expected output bus for frame time tt in mode m with drift accumulator a.
  function automatic logic [29:0] ref_out(input int tt, input logic [1:0] m, input int a);
    int px, ln, fl, kind, lvl, hlen;
    logic hs, vs;
    px = tt % LINE; ln = tt / LINE;
    fl = (m == 2'b10) ? (a >> 12) & 15 : 0;
    kind = 0; hs = 1'b0; vs = 1'b0; hlen = HS;   // kind: 0 black, 1 sync, 2 video
    case (m)
      2'b00: if (ln < 6) begin
        vs   = 1'b1;
        hlen = (ln < 2 || (ln == 2 && px < LINE / 2)) ? LSYNC : SSYNC;
        kind = ((px % (LINE / 2)) < hlen) ? 1 : 0;
      end
      2'b01: if (ln < BKV) begin
        vs   = 1'b1;
        kind = ((tt % EQP) < SSYNC) ? 0 : 1;
      end
      2'b10: if (ln < VVS) begin
        vs   = 1'b1;
        kind = (px < VSL) ? 1 : 0;
      end else hlen = HS_VEC;
      default: ;
    endcase
    if (m != 2'b11 && !vs) begin
      if (px < FP) kind = 0;
      else if (px < FP + hlen) begin kind = 1; hs = 1'b1; end
      else if (px < FP + hlen + BP) kind = 0;
      else kind = (m == 2'b10 && ln < VBE) ? 0 : 2;
    end
    case (kind)
      0:       lvl = fl + 12;
      1:       lvl = fl;
      default: lvl = 15 + px % 16;
    endcase
    if (lvl > 63) lvl = 63;
    if (m == 2'b11) lvl = 12;
    return {6'(lvl), hs, vs, (px == 0), (tt == 0), 9'(ln), 11'(px)};
  endfunction

  // One clock: drive inputs, advance the model on enabled cycles, compare.
  task automatic cyc(input logic ce_v, input logic [1:0] mode_v);
    @(negedge clk);
    ce = ce_v; mode = mode_v;
    @(posedge clk);
    if (ce_v) begin
      if (t == 0) mq = mode_v;
      exp_q = ref_out(t, mq, acc);
      if (mq == 2'b10) begin
        if (exp_q[22] && t < RAMP) acc = (acc + 2 > 65535) ? 65535 : acc + 2;
        else acc = (acc < 6) ? 0 : acc - 6;
      end else acc = 0;
      t = (t + 1) % FRAME;
    end
    #1;
    check("out", 32'(dut_bus), 32'(exp_q));
  endtask

  initial begin
    int hs_cnt, vs_cnt, ce_n, peak;
    logic c;
    reset = 1'b1; ce = 1'b0; mode = 2'b00;
    #22;
    check("rst_out", 32'(dut_bus), 32'd0);
    @(negedge clk); reset = 1'b0;

    // Frame 0: normal, continuous enable; vector requested from line 8 on.
    hs_cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      cyc(1'b1, (i >= 8 * LINE) ? 2'b10 : 2'b00);
      if (i == 0) check("fs_first", 32'(frame_start), 32'd1);
      if (line_no == 9'd6 && ref_hsync) hs_cnt++;
    end
    check("hs_len", 32'(hs_cnt), 32'(HS));

    // Frame 1: vector with drift; BK requested from line 10 on.
    peak = 0;
    for (int i = 0; i < FRAME; i++) begin
      cyc(1'b1, (i >= 10 * LINE) ? 2'b01 : 2'b10);
      if (ref_vsync && pixel_no >= 11'(VSL) && int'(cvbs) > peak) peak = int'(cvbs);
      if (line_no == 9'(VBE - 1) && pixel_no == 11'd0) check("drift_settle", 32'(cvbs), 32'd12);
    end
    check("drift_peak", 32'(peak), 32'(((RAMP * 2) >> 12) + 12));

    // Frame 2: BK with random enable; normal requested from line 9 on.
    ce_n = 0; vs_cnt = 0;
    while (ce_n < FRAME) begin
      c = ($urandom_range(3) != 0);
      cyc(c, (ce_n >= 9 * LINE) ? 2'b00 : 2'b01);
      if (c) begin
        ce_n++;
        if (ref_vsync) vs_cnt++;
      end
    end
    check("bk_vs_clocks", 32'(vs_cnt), 32'(BKV * LINE));

    // Frame 3: normal, enable toggling every clock, then async reset at line 3.
    for (int i = 0; i < 6 * LINE; i++) cyc((i % 2) == 0, 2'b00);
    check("ce_line", 32'(line_no), 32'd2);
    #1 reset = 1'b1;
    #1 check("async_rst", 32'(dut_bus), 32'd0);
    t = 0; acc = 0; mq = 2'b00; exp_q = '0;
    @(negedge clk); reset = 1'b0;

    // Idle after reset, random enable.
    for (int i = 0; i < 3000; i++) cyc(1'($urandom_range(1)), 2'b11);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
